// File: rtl/div_radix2_if.sv
// Handshake/operand bundle between the ALU and the iterative divider.
// The ALU drives the master side; the divider is the slave.
interface div_radix2_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
    output annul_i,
    input  result_o,
    input  ready_o
  );

  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
    input  annul_i,
    output result_o,
    output ready_o
  );
endinterface

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// One quotient bit per cycle, 32 iterations, result = {remainder, quotient}.
// Signed operation divides magnitudes and fixes the signs on the way out.
module div_radix2 (
  input  logic         clk,
  input  logic         rst,
  div_radix2_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIVZERO = 2'd1,
    ST_ON      = 2'd2,
    ST_END     = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg;
  logic [32:0] rem_reg;     // partial remainder
  logic [31:0] dvd_reg;     // dividend shifting out, quotient shifting in
  logic [31:0] dvs_reg;     // divisor magnitude
  logic        qneg_reg;
  logic        rneg_reg;
  logic [63:0] result_reg, result_next;
  logic        ready_reg, ready_next;

  // Operand conditioning: magnitudes for signed mode. 0x80000000 stays
  // 0x80000000, which is the right magnitude when read as unsigned.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  assign a_neg = bus.signed_div_i & bus.opdata1_i[31];
  assign b_neg = bus.signed_div_i & bus.opdata2_i[31];
  assign a_mag = a_neg ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
  assign b_mag = b_neg ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;

  // Flush from the pipeline or a late divide-by-zero abandons the iteration.
  logic cancel;
  assign cancel = ~bus.start_i | bus.annul_i;

  // One restoring step: shift, trial-subtract, keep or restore.
  logic [33:0] shift_val, diff;
  logic [32:0] iter_rem;
  logic [31:0] iter_quo;
  logic [31:0] quo_fix, rem_fix;
  always_comb begin
    shift_val = {rem_reg, dvd_reg[31]};
    diff      = shift_val - {2'b00, dvs_reg};
    if (!diff[33]) begin
      iter_rem = diff[32:0];
      iter_quo = {dvd_reg[30:0], 1'b1};
    end else begin
      iter_rem = shift_val[32:0];
      iter_quo = {dvd_reg[30:0], 1'b0};
    end
    quo_fix = qneg_reg ? (~iter_quo + 32'd1) : iter_quo;
    rem_fix = rneg_reg ? (~iter_rem[31:0] + 32'd1) : iter_rem[31:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start_i && bus.annul_i)       state_next = ST_DIVZERO;
        else if (bus.start_i)                 state_next = ST_ON;
      end
      ST_DIVZERO:                             state_next = ST_END;
      ST_ON: begin
        if (cancel)                           state_next = ST_IDLE;
        else if (cnt_reg == 5'd31)            state_next = ST_END;
      end
      ST_END:                                 state_next = ST_IDLE;
      default:                                state_next = ST_IDLE;
    endcase
  end

  // Output logic: ready decoded from the next state, result captured on
  // completion (normal or divide-by-zero) and held otherwise.
  always_comb begin
    ready_next  = (state_next == ST_END);
    result_next = result_reg;
    if (state_reg == ST_DIVZERO)
      result_next = 64'h0;
    else if (state_reg == ST_ON && state_next == ST_END)
      result_next = {rem_fix, quo_fix};
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_reg  <= 1'b0;
      result_reg <= 64'h0;
    end else begin
      ready_reg  <= ready_next;
      result_reg <= result_next;
    end
  end

  // Datapath: load conditioned operands on start, iterate while in ON.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= 5'd0;
      rem_reg  <= 33'd0;
      dvd_reg  <= 32'd0;
      dvs_reg  <= 32'd0;
      qneg_reg <= 1'b0;
      rneg_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && bus.start_i && !bus.annul_i) begin
      cnt_reg  <= 5'd0;
      rem_reg  <= 33'd0;
      dvd_reg  <= a_mag;
      dvs_reg  <= b_mag;
      qneg_reg <= a_neg ^ b_neg;
      rneg_reg <= a_neg;
    end else if (state_reg == ST_ON && !cancel) begin
      rem_reg  <= iter_rem;
      dvd_reg  <= iter_quo;
      cnt_reg  <= cnt_reg + 5'd1;
    end
  end

  assign bus.result_o = result_reg;
  assign bus.ready_o  = ready_reg;

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: directed cases, randomized operands
// against an arithmetic reference, cancel, reset and back-to-back timing.
module tb_div_radix2;
  logic clk;
  logic rst;
  div_radix2_if bus ();

  div_radix2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference: plain 64-bit arithmetic, truncating division, remainder
  // takes the dividend's sign; results wrap to 32 bits; b==0 gives zero.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'h0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Drive one request from the current cycle (cycle 0), hold start until
  // ready or a 40-cycle bound, then drop start and sample the next cycle.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] res, output logic dbl);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = (b == 32'd0);
    bus.start_i      = 1'b1;
    lat = -1;
    res = 64'h0;
    dbl = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.ready_o) begin
        lat = c;
        res = bus.result_o;
        break;
      end
    end
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    if (lat >= 0) begin
      @(posedge clk); #1;
      dbl = bus.ready_o;
    end
    $display("[TB] op sgn=%0d a=%h b=%h -> result=%h latency=%0d", sgn, a, b, res, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.ready_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0", bus.ready_o);
    end
    n_tests++;
    if (bus.result_o !== 64'h0) begin
      n_fail++; $display("FAIL reset_result: got %h want 0", bus.result_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic        sgn_t [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] a_t   [5] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] b_t   [5] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1};
    logic [63:0] e_t   [5] = '{{32'd2, 32'd14}, {32'hFFFFFFFF, 32'hFFFFFFFD},
                               {32'd1, 32'hFFFFFFFD}, {32'h0, 32'h80000000},
                               {32'h0, 32'hFFFFFFFF}};
    int lat; logic [63:0] res; logic dbl;
    for (int i = 0; i < 5; i++) begin
      run_op(sgn_t[i], a_t[i], b_t[i], lat, res, dbl);
      n_tests++;
      if (lat !== 33) begin
        n_fail++; $display("FAIL directed_latency[%0d]: got %0d want 33", i, lat);
      end
      n_tests++;
      if (res !== e_t[i]) begin
        n_fail++; $display("FAIL directed_result[%0d]: got %h want %h", i, res, e_t[i]);
      end
      n_tests++;
      if (dbl !== 1'b0) begin
        n_fail++; $display("FAIL directed_ready_pulse[%0d]: ready high after END", i);
      end
    end
  endtask

  task automatic test_divzero();
    int lat; logic [63:0] res; logic dbl;
    run_op(1'b0, 32'd12345, 32'd0, lat, res, dbl);
    n_tests++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL divzero_latency: got %0d want 2", lat);
    end
    n_tests++;
    if (res !== 64'h0) begin
      n_fail++; $display("FAIL divzero_result: got %h want 0", res);
    end
  endtask

  task automatic test_random();
    int lat; logic [63:0] res, exp_v; logic dbl;
    logic sgn; logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2, 3: b = 32'($urandom_range(1, 15));
        4, 5, 6: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (b == 32'd0 && i % 2 == 0) b = 32'd3;
      exp_v = ref_div(sgn, a, b);
      run_op(sgn, a, b, lat, res, dbl);
      n_tests++;
      if (lat !== ((b == 32'd0) ? 2 : 33)) begin
        n_fail++; $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat,
                           (b == 32'd0) ? 2 : 33);
      end
      n_tests++;
      if (res !== exp_v) begin
        n_fail++; $display("FAIL random_result[%0d]: sgn=%0d a=%h b=%h got %h want %h",
                           i, sgn, a, b, res, exp_v);
      end
    end
  endtask

  task automatic test_cancel();
    int lat; logic [63:0] res, prev; logic dbl; logic seen;
    prev = bus.result_o;
    seen = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (bus.ready_o) seen = 1'b1;
    end
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    if (bus.ready_o) seen = 1'b1;
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL cancel_no_ready: got ready during cancelled op");
    end
    n_tests++;
    if (bus.result_o !== prev) begin
      n_fail++; $display("FAIL cancel_result_held: got %h want %h", bus.result_o, prev);
    end
    run_op(1'b0, 32'd50, 32'd5, lat, res, dbl);
    n_tests++;
    if (lat !== 33) begin
      n_fail++; $display("FAIL cancel_restart_latency: got %0d want 33", lat);
    end
    n_tests++;
    if (res !== {32'd0, 32'd10}) begin
      n_fail++; $display("FAIL cancel_restart_result: got %h want %h", res, {32'd0, 32'd10});
    end
  endtask

  // A one-cycle annul mid-iteration aborts; start still held restarts from
  // the following IDLE cycle, so ready lands 33 cycles after that.
  task automatic test_annul_midop();
    int first; logic [63:0] res;
    first = -1;
    res   = 64'h0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (c == 5) bus.annul_i = 1'b1;
      if (c == 6) bus.annul_i = 1'b0;
      if (bus.ready_o && first < 0) begin
        first = c;
        res   = bus.result_o;
        break;
      end
    end
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    $display("[TB] annul mid-op -> ready cycle=%0d result=%h", first, res);
    n_tests++;
    if (first !== 39) begin
      n_fail++; $display("FAIL annul_midop_latency: got %0d want 39", first);
    end
    n_tests++;
    if (res !== {32'd1, 32'd333}) begin
      n_fail++; $display("FAIL annul_midop_result: got %h want %h", res, {32'd1, 32'd333});
    end
  endtask

  task automatic test_reset_midop();
    int lat; logic [63:0] res, exp_v; logic dbl;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
    end
    rst         = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (bus.ready_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_midop_ready: got %b want 0", bus.ready_o);
    end
    n_tests++;
    if (bus.result_o !== 64'h0) begin
      n_fail++; $display("FAIL rst_midop_result: got %h want 0", bus.result_o);
    end
    rst = 1'b0;
    exp_v = ref_div(1'b1, 32'hFFFFFF9C, 32'd7);
    run_op(1'b1, 32'hFFFFFF9C, 32'd7, lat, res, dbl);
    n_tests++;
    if (lat !== 33) begin
      n_fail++; $display("FAIL rst_after_latency: got %0d want 33", lat);
    end
    n_tests++;
    if (res !== exp_v) begin
      n_fail++; $display("FAIL rst_after_result: got %h want %h", res, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    int first, second; logic [63:0] r1, r2, e1, e2;
    first = -1; second = -1; r1 = 64'h0; r2 = 64'h0;
    e1 = ref_div(1'b0, 32'hDEADBEEF, 32'd1234);
    e2 = ref_div(1'b1, 32'hFFFFFFF9, 32'd2);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'hDEADBEEF;
    bus.opdata2_i    = 32'd1234;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (bus.ready_o) begin
        if (first < 0) begin
          first = c;
          r1    = bus.result_o;
          bus.signed_div_i = 1'b1;
          bus.opdata1_i    = 32'hFFFFFFF9;
          bus.opdata2_i    = 32'd2;
        end else begin
          second = c;
          r2     = bus.result_o;
          break;
        end
      end
    end
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    $display("[TB] back-to-back -> ready cycles %0d,%0d results %h,%h", first, second, r1, r2);
    n_tests++;
    if (first !== 33) begin
      n_fail++; $display("FAIL b2b_first_latency: got %0d want 33", first);
    end
    n_tests++;
    if (second !== 67) begin
      n_fail++; $display("FAIL b2b_second_latency: got %0d want 67", second);
    end
    n_tests++;
    if (r1 !== e1) begin
      n_fail++; $display("FAIL b2b_first_result: got %h want %h", r1, e1);
    end
    n_tests++;
    if (r2 !== e2) begin
      n_fail++; $display("FAIL b2b_second_result: got %h want %h", r2, e2);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_divzero();
    test_random();
    test_cancel();
    test_annul_midop();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
